mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM between instruction fetch and load/store.
// Optional ARB_FAIR_EN: after a load/store completes, the next collision goes to fetch.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic [31:0] if_data,
   output logic        if_done,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_len,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic [31:0] ram_addr,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] IF_RD  = 3'd1;
   localparam logic [2:0] MEM_RD = 3'd2;
   localparam logic [2:0] MEM_WR = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [2:0]  state;
   logic [2:0]  cnt;
   logic [2:0]  nbytes;
   logic [31:0] base;
   logic [31:0] wdata;
   logic        is_if;
   logic [31:0] rbuf;
   logic [31:0] rbuf_nxt;
   logic [31:0] if_data_q;
   logic [31:0] mem_rdata_q;
   logic [1:0]  sel;
   logic        if_ok;
   logic        pick_if;
   logic        pick_mem;
   logic        active;
   logic [2:0]  len_n;

`ifdef ARB_FAIR_EN
   logic        last_mem;
`endif

   always_comb begin
      len_n = 3'd4;
      unique case (1'b1)
         mem_len == 2'b00: len_n = 3'd1;
         mem_len == 2'b01: len_n = 3'd2;
         default:          len_n = 3'd4;
      endcase
   end

   // A flush in the same cycle as a fetch request cancels that grant.
   assign if_ok = if_req && !if_flush;
`ifdef ARB_FAIR_EN
   assign pick_if = if_ok && (!mem_req || last_mem);
`else
   assign pick_if = if_ok && !mem_req;
`endif
   assign pick_mem = mem_req && !pick_if;

   // Byte arriving now belongs to the address presented one cycle earlier.
   assign sel      = cnt[1:0] - 2'd1;
   assign rbuf_nxt = rbuf | ({24'd0, ram_din} << {sel, 3'b000});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         nbytes      <= '0;
         base        <= '0;
         wdata       <= '0;
         is_if       <= 1'b0;
         rbuf        <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
`ifdef ARB_FAIR_EN
         last_mem    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cnt  <= '0;
               rbuf <= '0;
               if (pick_mem) begin
                  base   <= mem_addr;
                  wdata  <= mem_wdata;
                  nbytes <= len_n;
                  is_if  <= 1'b0;
                  state  <= mem_we ? MEM_WR : MEM_RD;
               end else if (pick_if) begin
                  base   <= if_addr;
                  wdata  <= '0;
                  nbytes <= 3'd4;
                  is_if  <= 1'b1;
                  state  <= IF_RD;
`ifdef ARB_FAIR_EN
                  if (mem_req) last_mem <= 1'b0;
`endif
               end
            end
            IF_RD, MEM_RD: begin
               if (state == IF_RD && if_flush) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
                  if (cnt != 3'd0) rbuf <= rbuf_nxt;
                  if (cnt == nbytes) begin
                     state <= DONE;
                     if (is_if) if_data_q <= rbuf_nxt;
                     else mem_rdata_q <= rbuf_nxt;
                  end
               end
            end
            MEM_WR: begin
               cnt <= cnt + 3'd1;
               if (cnt == nbytes - 3'd1) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
`ifdef ARB_FAIR_EN
               if (!is_if) last_mem <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign active = (state == IF_RD || state == MEM_RD || state == MEM_WR)
                   && (cnt < nbytes);

   assign ram_addr  = active ? base + {29'd0, cnt} : 32'd0;
   assign ram_wr    = active && (state == MEM_WR);
   assign ram_dout  = ram_wr ? 8'(wdata >> {cnt[1:0], 3'b000}) : 8'd0;
   assign if_done   = (state == DONE) && is_if;
   assign mem_done  = (state == DONE) && !is_if;
   assign if_data   = if_data_q;
   assign mem_rdata = mem_rdata_q;

endmodule
